// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction fetch: PC, credit-limited imem requests, in-order instruction buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_kill_cnt;

  // Pending-PC queue holds only live (not killed) requests, so killed responses never pop it.
  logic [31:0]   r_pend_pc [FIFO_DEPTH];
  logic [PW-1:0] r_pend_rd;
  logic [PW-1:0] r_pend_wr;
  logic [CW-1:0] r_pend_cnt;

  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0] r_fifo_rd;
  logic [PW-1:0] r_fifo_wr;
  logic [CW-1:0] r_fifo_cnt;

  logic [CW:0]   w_inflight;
  logic          w_credit;
  logic          w_req_fire;
  logic          w_rsp_live;
  logic          w_push;
  logic          w_pop;
  logic          w_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_unused   = ^redirect_pc[1:0];
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
  assign w_credit   = w_inflight < (CW+1)'(FIFO_DEPTH);

  assign imem_req_valid = !rst && !redirect_valid && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_live = imem_rsp_valid && (r_kill_cnt == '0);
  assign w_push     = w_rsp_live && !redirect_valid;
  assign w_pop      = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid = !rst && (r_fifo_cnt != '0);
  assign instr       = instr_valid ? r_fifo_data[r_fifo_rd] : 32'h0;
  assign instr_pc    = instr_valid ? r_fifo_pc[r_fifo_rd]   : 32'h0;
  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= {RESET_PC[31:2], 2'b00};
      r_outstanding <= '0;
      r_kill_cnt    <= '0;
      r_pend_rd     <= '0;
      r_pend_wr     <= '0;
      r_pend_cnt    <= '0;
      r_fifo_rd     <= '0;
      r_fifo_wr     <= '0;
      r_fifo_cnt    <= '0;
    end else begin
      // Killed requests stay outstanding until their responses drain, keeping credit honest.
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_kill_cnt <= r_outstanding - CW'(imem_rsp_valid);
        r_pend_rd  <= '0;
        r_pend_wr  <= '0;
        r_pend_cnt <= '0;
        r_fifo_rd  <= '0;
        r_fifo_wr  <= '0;
        r_fifo_cnt <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc           <= r_fetch_pc + 32'd4;
          r_pend_pc[r_pend_wr] <= r_fetch_pc;
          r_pend_wr            <= ptr_inc(r_pend_wr);
        end
        if (w_rsp_live) begin
          r_pend_rd <= ptr_inc(r_pend_rd);
        end
        r_pend_cnt <= r_pend_cnt + CW'(w_req_fire) - CW'(w_rsp_live);
        if (imem_rsp_valid && (r_kill_cnt != '0)) begin
          r_kill_cnt <= r_kill_cnt - CW'(1);
        end
        if (w_push) begin
          r_fifo_data[r_fifo_wr] <= imem_rsp_data;
          r_fifo_pc[r_fifo_wr]   <= r_pend_pc[r_pend_rd];
          r_fifo_wr              <= ptr_inc(r_fifo_wr);
        end
        if (w_pop) begin
          r_fifo_rd <= ptr_inc(r_fifo_rd);
        end
        r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Scoreboard bench for fetch_unit with a behavioural in-order imem.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic killed; } oreq_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] data; } exp_t;

  oreq_t       oq[$];
  oreq_t       cur;
  exp_t        sb[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_pc;
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          first_acc_cyc;
  int          first_vld_cyc;
  bit          rsp_en;
  bit          got_first_pop;
  logic [31:0] first_pop_pc;
  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_instr_valid;
  bit          cap_sub;
  logic [31:0] cap_instr;
  logic [6:0]  cap_op;
  logic [2:0]  cap_f3;
  logic [6:0]  cap_f7;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h40B5_0533;
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    exp_t e;
    logic exp_req;
    @(negedge clk);
    cyc++;
    s_req_valid   = imem_req_valid;
    s_req_addr    = imem_req_addr;
    s_instr_valid = instr_valid;
    if (rst) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      oq.delete();
      sb.delete();
      exp_pc = 32'h0;
    end else begin
      exp_req = !redirect_valid && ((oq.size() + int'(imem_rsp_valid) + sb.size()) < 2);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
      chk("instr_valid", 32'(instr_valid), 32'(sb.size() > 0));
      if (!instr_valid) begin
        chk("idle_instr", instr, 32'h0);
        chk("idle_pc", instr_pc, 32'h0);
        chk("idle_fields", 32'({opcode, funct3, funct7}), 32'h0);
      end
      if (instr_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (redirect_valid) begin
        sb.delete();
        foreach (oq[i]) oq[i].killed = 1'b1;
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (instr_valid && instr_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("pop_pc", instr_pc, e.pc);
          chk("pop_instr", instr, e.data);
          chk("pop_fields", 32'({opcode, funct3, funct7}),
              32'({e.data[6:0], e.data[14:12], e.data[31:25]}));
          if (!got_first_pop) begin
            first_pop_pc  = instr_pc;
            got_first_pop = 1'b1;
          end
          if (instr_pc == 32'h40) begin
            cap_sub   = 1'b1;
            cap_instr = instr;
            cap_op    = opcode;
            cap_f3    = funct3;
            cap_f7    = funct7;
          end
        end
        if (imem_rsp_valid && !cur.killed) sb.push_back({cur.addr, mem_word(cur.addr)});
        if (imem_req_valid && imem_req_ready) begin
          oq.push_back({imem_req_addr, 1'b0});
          acc_log.push_back(imem_req_addr);
          exp_pc = exp_pc + 32'd4;
          if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst || !rsp_en || oq.size() == 0) begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      cur            = oq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(cur.addr);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    cycle();
    cycle();
    rst           = 1'b0;
    cyc           = 0;
    first_acc_cyc = -1;
    first_vld_cyc = -1;
    got_first_pop = 1'b0;
    acc_log.delete();
  endtask

  initial begin
    bit found;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    rsp_en         = 1'b1;
    cur            = '0;
    cap_sub        = 1'b0;

    // Streaming from reset
    do_reset();
    repeat (12) cycle();
    chk("first_latency", 32'(first_vld_cyc - first_acc_cyc), 32'd2);
    chk("stream_acc0", acc_log[0], 32'h0);
    chk("stream_acc1", acc_log[1], 32'h4);
    chk("stream_acc2", acc_log[2], 32'h8);
    chk("stream_first_pc", first_pop_pc, 32'h0);

    // Decode back-pressure fills credit
    instr_ready = 1'b0;
    do_reset();
    repeat (6) cycle();
    chk("bp_acc_count", 32'(acc_log.size()), 32'd2);
    chk("bp_req_valid", 32'(s_req_valid), 32'd0);
    instr_ready = 1'b1;
    repeat (6) cycle();
    chk("bp_first_pc", first_pop_pc, 32'h0);
    chk("bp_resume_addr", acc_log[2], 32'h8);

    // imem stall holds the request
    do_reset();
    cycle();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_valid", 32'(s_req_valid), 32'd1);
      chk("stall_addr", s_req_addr, 32'h4);
    end
    imem_req_ready = 1'b1;
    cycle();
    chk("stall_acc_count", 32'(acc_log.size()), 32'd2);
    chk("stall_acc_addr", acc_log[1], 32'h4);

    // Redirect with two requests in flight
    rsp_en = 1'b0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    cycle();
    chk("flight_acc0", acc_log[0], 32'h8);
    chk("flight_acc1", acc_log[1], 32'hC);
    rsp_en = 1'b1;
    cycle();
    chk("flight_full", 32'(s_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    got_first_pop  = 1'b0;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("redir_req_valid", 32'(s_req_valid), 32'd1);
    chk("redir_req_addr", s_req_addr, 32'h100);
    repeat (6) cycle();
    chk("redir_first_pc", first_pop_pc, 32'h100);

    // R-type field slicing
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    repeat (8) cycle();
    chk("sub_seen", 32'(cap_sub), 32'd1);
    chk("sub_instr", cap_instr, 32'h40B5_0533);
    chk("sub_opcode", 32'(cap_op), 32'h33);
    chk("sub_funct3", 32'(cap_f3), 32'h0);
    chk("sub_funct7", 32'(cap_f7), 32'h20);

    // Redirect colliding with a pop and a live response
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_rsp_valid && !cur.killed && sb.size() > 0) found = 1'b1;
      else cycle();
    end
    chk("collide_found", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("collide_empty", 32'(s_instr_valid), 32'd0);
    chk("collide_req_valid", 32'(s_req_valid), 32'd1);
    chk("collide_req_addr", s_req_addr, 32'h200);
    repeat (4) cycle();

    // PC wrap at the top of the address space
    acc_log.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    repeat (5) cycle();
    chk("wrap_count", 32'(acc_log.size() >= 2), 32'd1);
    chk("wrap_acc0", acc_log[0], 32'hFFFF_FFFC);
    chk("wrap_acc1", acc_log[1], 32'h0);
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
